pixel_diffuser: RTL
===================

// Module: pixel_diffuser
// PURPOSE
//  Keystream consumer directly downstream of the chaotic mixer. Pairs each 8-bit pixel with one
//  keystream word, applies add-then-XOR chained diffusion (ciphertext feedback), and emits cipher/plain bytes.
//  Handles one frame of NUM_PIXELS per start. Backpressures the keystream source and the pixel source.
// PARAMETERS
//  PIX_W       8       pixel / key byte width
//  KS_W        23      mixer output width; only ks_data[PIX_W-1:0] is used
//  NUM_PIXELS  65536   pixels per frame (256x256)
//  CNT_W       16      pixel counter width; must satisfy 2**CNT_W >= NUM_PIXELS
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  start      in   1      frame start pulse; sampled only in IDLE
//  mode       in   1      0 = encrypt, 1 = decrypt; latched on start
//  iv         in   PIX_W  chaining seed; latched into prev on start
//  ks_data    in   KS_W   keystream word from mixer
//  ks_valid   in   1      keystream word available
//  ks_ready   out  1      keystream word consumed this cycle; also used as the generator advance enable
//  pix_in     in   PIX_W  input pixel (plain in encrypt mode, cipher in decrypt mode)
//  pix_valid  in   1      pixel available
//  pix_ready  out  1      pixel consumed this cycle
//  out_data   out  PIX_W  result byte
//  out_valid  out  1      out_data valid
//  out_ready  in   1      downstream accepts out_data
//  out_last   out  1      qualifies the final byte of the frame
//  busy       out  1      high whenever state != IDLE
//  done       out  1      one-cycle pulse when the frame is fully drained
// BEHAVIOUR
//  Reset: state=IDLE; prev, cnt, out_data=0; out_valid, out_last, done=0; mode_r=0.
//  FSM states:
//   - IDLE: start -> RUN; latch mode_r=mode, prev=iv, cnt=0. start is ignored in RUN and DONE.
//   - RUN: after the fire with cnt==NUM_PIXELS-1 -> DONE.
//   - DONE: once out_valid==0, or (out_valid && out_ready), pulse done for 1 cycle -> IDLE.
//  Handshake:
//   - out_free = !out_valid || out_ready.
//   - fire = (state==RUN) && pix_valid && ks_valid && out_free.
//   - pix_ready = RUN && ks_valid && out_free.
//   - ks_ready  = RUN && pix_valid && out_free.
//   - A keystream word and a pixel are always consumed together. Never one without the other.
//  Datapath (mod 2**PIX_W), with k = ks_data[PIX_W-1:0]:
//   - encrypt: c = (pix_in + k) ^ prev;    out_data <= c;  prev <= c.
//   - decrypt: p = (pix_in ^ prev) - k;    out_data <= p;  prev <= pix_in.
//   - Carry and borrow are discarded (wrap-around).
//  Latency: 1 cycle from fire to out_valid.
//   - On fire: out_valid <= 1, cnt <= cnt+1, out_last <= (cnt==NUM_PIXELS-1).
//   - Without a new fire: out_valid <= 0 when out_ready is high.
//  Stalls: out_data and out_last hold stable while out_valid && !out_ready.
//   - Back-to-back fires with out_ready held high sustain 1 byte per cycle.
//  Frame end: no pixel or keystream is consumed after the last fire; cnt does not wrap within a frame.
//  Reset mid-frame: frame abandoned immediately, all state returns to reset values; no done pulse.
// STRUCTURE
//  Shared package chaos_pkg:
//   - PIX_W and KS_W defaults.
//   - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
//   - MODE_ENC=1'b0, MODE_DEC=1'b1.
//  One combinational sub-module, diffuse_unit:
//   - inputs: mode, pix, k, prev. outputs: result, next_prev.
//   - Shared with the future decrypt-side top. FSM, counter and output register stay in pixel_diffuser.
// TESTING
//  1 Encrypt, iv=00, k=10:
//    - pixels 05,05 -> out 15,00.
//    - k=20 with pixel F0 (prev=00) -> 10 (add wraps).
//  2 Decrypt round-trip:
//    - feed the cipher bytes from test 1 with the same iv and keystream -> out 05,05.
//    - 64 random bytes encrypted then decrypted must match.
//  3 Backpressure:
//    - out_ready=0 for 3 cycles with data pending -> out_data stable; pix_ready=ks_ready=0; no counter advance.
//  4 Starvation:
//    - ks_valid=0 with pix_valid=1 -> pix_ready=0, no output.
//    - pix_valid=0 with ks_valid=1 -> ks_ready=0.
//  5 Frame end, NUM_PIXELS=4:
//    - out_last only on the 4th byte.
//    - done pulses exactly once after it is accepted; busy falls the same cycle.
//    - a start asserted in RUN is ignored.
//  6 Reset mid-frame:
//    - rst after 2 pixels -> all outputs 0 next edge.
//    - a new start with iv=00 reproduces test 1 values.

Source files
------------

// File: rtl/chaos_pkg.sv
// Shared constants and types for the keystream diffusion path.
// Purely declarative: no logic, no latency.
// Backpressure is not applicable here.
package chaos_pkg;

    localparam int PIX_W = 8;
    localparam int KS_W  = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/pixel_diffuser_if.sv
// Bundles the keystream input, pixel input and result output streams.
// No logic and no latency; it only groups the signals.
// The ready signals flow from slave (diffuser) to master (sources/sink side).
interface pixel_diffuser_if
    import chaos_pkg::*;
#(
    parameter int P_W = PIX_W,
    parameter int K_W = KS_W
);
    logic [K_W-1:0] ks_data;
    logic           ks_valid;
    logic           ks_ready;
    logic [P_W-1:0] pix_in;
    logic           pix_valid;
    logic           pix_ready;
    logic [P_W-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;

    modport master (
        output ks_data, ks_valid, pix_in, pix_valid, out_ready,
        input  ks_ready, pix_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  ks_data, ks_valid, pix_in, pix_valid, out_ready,
        output ks_ready, pix_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/diffuse_unit.sv
// Add-then-XOR chained diffusion for one byte, encrypt or decrypt.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is used.
module diffuse_unit
    import chaos_pkg::*;
(
    input  logic             mode,
    input  logic [PIX_W-1:0] pix,
    input  logic [PIX_W-1:0] k,
    input  logic [PIX_W-1:0] prev,
    output logic [PIX_W-1:0] result,
    output logic [PIX_W-1:0] next_prev
);

    // Encrypt chains on the produced cipher byte; decrypt chains on the
    // incoming cipher byte, so both sides walk the same prev sequence.
    always_comb begin
        result    = '0;
        next_prev = '0;
        if (mode == MODE_ENC) begin
            result    = (pix + k) ^ prev;
            next_prev = result;
        end else begin
            result    = (pix ^ prev) - k;
            next_prev = pix;
        end
    end

endmodule

// File: rtl/pixel_diffuser.sv
// Pairs each pixel with one keystream byte and applies chained diffusion over a frame.
// 1 cycle from fire (pixel and keystream accepted together) to out_valid.
// Stalls both sources while the output register is full and not being accepted.
module pixel_diffuser
    import chaos_pkg::*;
#(
    parameter int NUM_PIXELS = 65536,
    parameter int CNT_W      = 16     // 2**CNT_W must cover NUM_PIXELS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [PIX_W-1:0] iv,
    pixel_diffuser_if.slave  bus,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIXELS - 1);

    state_t           state;
    state_t           state_nxt;
    logic             mode_r;
    logic [PIX_W-1:0] prev;
    logic [CNT_W-1:0] cnt;
    logic             out_free;
    logic             fire;
    logic             last_fire;
    logic [PIX_W-1:0] result;
    logic [PIX_W-1:0] next_prev;
    logic             unused_ks_hi;

    // Only the low byte of the mixer word is keystream material.
    assign unused_ks_hi = ^bus.ks_data[KS_W-1:PIX_W];

    assign out_free  = !bus.out_valid || bus.out_ready;
    assign fire      = (state == RUN) && bus.pix_valid && bus.ks_valid && out_free;
    assign last_fire = fire && (cnt == LAST_CNT);

    // Each ready depends on the other stream's valid so a pixel and a
    // keystream word can only ever be taken in the same cycle.
    assign bus.pix_ready = (state == RUN) && bus.ks_valid && out_free;
    assign bus.ks_ready  = (state == RUN) && bus.pix_valid && out_free;
    assign busy          = (state != IDLE);

    diffuse_unit u_diffuse (
        .mode      (mode_r),
        .pix       (bus.pix_in),
        .k         (bus.ks_data[PIX_W-1:0]),
        .prev      (prev),
        .result    (result),
        .next_prev (next_prev)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencing: wait for start, run NUM_PIXELS fires, drain the last byte.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)     state_nxt = RUN;
            RUN:  if (last_fire) state_nxt = DONE;
            DONE: if (out_free)  state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Frame context, chaining register, pixel counter, output register and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r        <= MODE_ENC;
            prev          <= '0;
            cnt           <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= (state == DONE) && out_free;

            if (state == IDLE && start) begin
                mode_r <= mode;
                prev   <= iv;
                cnt    <= '0;
            end

            if (fire) begin
                bus.out_data  <= result;
                bus.out_valid <= 1'b1;
                bus.out_last  <= last_fire;
                prev          <= next_prev;
                // Hold at the last index so the counter never wraps inside a frame.
                if (!last_fire) begin
                    cnt <= cnt + 1'b1;
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
        end
    end

endmodule
